sw_debounce: RTL and testbench



---
 rtl/sw_debounce_if.sv | 32 +++
 rtl/sw_debounce.sv | 129 ++++++++++++
 tb/tb_sw_debounce.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sw_debounce_if                                        |
// | Brief    : raw switch inputs and conditioned outputs of debounce |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface sw_debounce_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] sw_raw;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] toggle;

  modport master (
    output sw_raw,
    input  level,
    input  rise,
    input  fall,
    input  toggle
  );

  modport slave (
    input  sw_raw,
    output level,
    output rise,
    output fall,
    output toggle
  );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sw_debounce                                           |
// | Brief    : 2-flop sync, per-channel bounce filter, edge pulses,  |
// |            toggle flags; auto-repeat via SW_DEBOUNCE_REPEAT_EN   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module sw_debounce #(
  parameter int NCH          = 4,
  parameter int CNT_W        = 18,
  parameter int STABLE_CNT   = 50000,
  parameter bit ACTIVE_LOW   = 1'b0
`ifdef SW_DEBOUNCE_REPEAT_EN
  ,
  parameter int RPT_W        = 26,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
`endif
) (
  input  logic          clk0,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CNT - 1);
`ifdef SW_DEBOUNCE_REPEAT_EN
  localparam logic [RPT_W-1:0] C_DELAY_MAX = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] C_RATE_MAX  = RPT_W'(REPEAT_RATE - 1);
`endif

  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;

  // Polarity is folded in before the first flop so reset's 0 means inactive
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.sw_raw ^ {NCH{ACTIVE_LOW}};
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             acc_q, acc_d;
    logic             toggle_q, toggle_d;
`ifdef SW_DEBOUNCE_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_run_q, rpt_run_d;
    logic             w_rpt_fire;
`endif

    always_comb begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      acc_d    = 1'b0;
      fall_d   = 1'b0;
      // acc_q marks an accepted rise only, so repeat pulses never flip toggle
      toggle_d = toggle_q ^ acc_q;
      if (s2_q[i] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q != C_CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        level_d = s2_q[i];
        cnt_d   = '0;
        acc_d   = s2_q[i];
        fall_d  = ~s2_q[i];
      end
`ifdef SW_DEBOUNCE_REPEAT_EN
      rpt_d      = rpt_q;
      rpt_run_d  = rpt_run_q;
      w_rpt_fire = 1'b0;
      // Hold off on a level change so a repeat can never coincide with fall
      if (!level_q || (level_d != level_q)) begin
        rpt_d     = '0;
        rpt_run_d = 1'b0;
      end else if (rpt_q == (rpt_run_q ? C_RATE_MAX : C_DELAY_MAX)) begin
        w_rpt_fire = 1'b1;
        rpt_d      = '0;
        rpt_run_d  = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
      rise_d = acc_d | w_rpt_fire;
`else
      rise_d = acc_d;
`endif
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        acc_q     <= 1'b0;
        toggle_q  <= 1'b0;
`ifdef SW_DEBOUNCE_REPEAT_EN
        rpt_q     <= '0;
        rpt_run_q <= 1'b0;
`endif
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        rise_q    <= rise_d;
        fall_q    <= fall_d;
        acc_q     <= acc_d;
        toggle_q  <= toggle_d;
`ifdef SW_DEBOUNCE_REPEAT_EN
        rpt_q     <= rpt_d;
        rpt_run_q <= rpt_run_d;
`endif
      end
    end

    assign bus.level[i]  = level_q;
    assign bus.rise[i]   = rise_q;
    assign bus.fall[i]   = fall_q;
    assign bus.toggle[i] = toggle_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_sw_debounce                                        |
// | Brief    : directed bench for sw_debounce, STABLE_CNT=8, NCH=2   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_sw_debounce;
  localparam int NCH        = 2;
  localparam int CNT_W      = 4;
  localparam int STABLE_CNT = 8;

  logic clk0  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk0 = ~clk0;

  sw_debounce_if #(.NCH(NCH)) bus ();
  sw_debounce_if #(.NCH(NCH)) bus_al ();

  sw_debounce #(
    .NCH(NCH), .CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT), .ACTIVE_LOW(1'b0)
`ifdef SW_DEBOUNCE_REPEAT_EN
    , .RPT_W(8), .REPEAT_DELAY(20), .REPEAT_RATE(6)
`endif
  ) u_dut (
    .clk0 (clk0),
    .rst_n(rst_n),
    .bus  (bus)
  );

  sw_debounce #(
    .NCH(NCH), .CNT_W(CNT_W), .STABLE_CNT(STABLE_CNT), .ACTIVE_LOW(1'b1)
`ifdef SW_DEBOUNCE_REPEAT_EN
    , .RPT_W(8), .REPEAT_DELAY(20), .REPEAT_RATE(6)
`endif
  ) u_dut_al (
    .clk0 (clk0),
    .rst_n(rst_n),
    .bus  (bus_al)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk0);
      @(negedge clk0);
    end
  endtask

  task automatic run_seen(input int n, output logic [NCH-1:0] r, output logic [NCH-1:0] f);
    r = '0;
    f = '0;
    repeat (n) begin
      step(1);
      r |= bus.rise;
      f |= bus.fall;
    end
  endtask

  always @(negedge clk0) begin
    if (rst_n) check("excl", bus.rise & bus.fall, 2'b00);
  end

  logic [NCH-1:0] r, f;

  initial begin
    bus.sw_raw    = 2'b00;
    bus_al.sw_raw = 2'b11;
    step(3);
    check("rst_level", bus.level, 2'b00);
    check("rst_rise", bus.rise, 2'b00);
    check("rst_fall", bus.fall, 2'b00);
    check("rst_toggle", bus.toggle, 2'b00);
    rst_n = 1'b1;
    step(2);

    // Clean step: accepted on the 10th edge
    bus.sw_raw = 2'b01;
    step(9);
    check("t1_level_pre", bus.level, 2'b00);
    check("t1_rise_pre", bus.rise, 2'b00);
    step(1);
    check("t1_level", bus.level, 2'b01);
    check("t1_rise", bus.rise, 2'b01);
    step(1);
    check("t1_rise_1cyc", bus.rise, 2'b00);
    check("t1_toggle", bus.toggle, 2'b01);

    // Short release glitch, then a real release
    bus.sw_raw = 2'b00;
    step(5);
    bus.sw_raw = 2'b01;
    run_seen(12, r, f);
    check("t3_glitch_fall", f, 2'b00);
    check("t3_glitch_level", bus.level, 2'b01);
    bus.sw_raw = 2'b00;
    step(9);
    check("t3_fall_pre", bus.fall, 2'b00);
    step(1);
    check("t3_fall", bus.fall, 2'b01);
    check("t3_level", bus.level, 2'b00);
    step(1);
    check("t3_fall_1cyc", bus.fall, 2'b00);
    check("t3_toggle_keep", bus.toggle, 2'b01);

    // Bounce: 3-cycle runs never qualify
    r = '0;
    f = '0;
    for (int i = 0; i < 40; i++) begin
      bus.sw_raw = ((i / 3) % 2 == 0) ? 2'b01 : 2'b00;
      step(1);
      r |= bus.rise;
      f |= bus.fall;
    end
    check("t2_bounce_rise", r, 2'b00);
    check("t2_bounce_fall", f, 2'b00);
    bus.sw_raw = 2'b01;
    step(9);
    check("t2_rise_pre", bus.rise, 2'b00);
    step(1);
    check("t2_rise", bus.rise, 2'b01);
    step(1);
    check("t2_toggle", bus.toggle, 2'b00);
`ifdef SW_DEBOUNCE_REPEAT_EN
    run_seen(18, r, f);
    check("t6_quiet_delay", r, 2'b00);
    step(1);
    check("t6_rpt20", bus.rise, 2'b01);
    run_seen(5, r, f);
    check("t6_quiet_rate1", r, 2'b00);
    step(1);
    check("t6_rpt26", bus.rise, 2'b01);
    run_seen(5, r, f);
    check("t6_quiet_rate2", r, 2'b00);
    step(1);
    check("t6_rpt32", bus.rise, 2'b01);
    step(1);
    check("t6_toggle_once", bus.toggle, 2'b00);
`endif
    bus.sw_raw = 2'b00;
    step(10);
    check("t2_release", bus.level, 2'b00);
    step(2);

    // Simultaneous rise on both channels
    bus.sw_raw = 2'b11;
    step(9);
    check("t4_rise_pre", bus.rise, 2'b00);
    step(1);
    check("t4_rise_both", bus.rise, 2'b11);
    check("t4_level_both", bus.level, 2'b11);
    step(1);
    check("t4_toggle_both", bus.toggle, 2'b11);
    bus.sw_raw = 2'b00;
    step(12);
    check("t4_release", bus.level, 2'b00);

    // Active-low instance: idle-high pins read inactive
    check("al_idle", bus_al.level, 2'b00);
    bus_al.sw_raw = 2'b10;
    step(9);
    check("al_rise_pre", bus_al.rise, 2'b00);
    step(1);
    check("al_rise", bus_al.rise, 2'b01);
    check("al_level", bus_al.level, 2'b01);

    // Reset mid-count on channel 0
    bus.sw_raw = 2'b10;
    step(12);
    check("t5_level_pre", bus.level, 2'b10);
    bus.sw_raw = 2'b11;
    step(7);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_level", bus.level, 2'b00);
    check("t5_rst_toggle", bus.toggle, 2'b00);
    check("t5_rst_al_level", bus_al.level, 2'b00);
    @(negedge clk0);
    @(negedge clk0);
    rst_n = 1'b1;
    step(9);
    check("t5_rise_pre", bus.rise, 2'b00);
    check("t5_level_pre2", bus.level, 2'b00);
    step(1);
    check("t5_rise", bus.rise, 2'b11);
    check("t5_level", bus.level, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
